pipe_hazard_scoreboard: RTL and testbench
=========================================

Name: pipe_hazard_scoreboard

Overview:
Parametrised hazard-detection and forwarding unit for the in-order pipeline core.
- Tracks in-flight register writers across DEPTH post-decode stages in an internal shift scoreboard.
- Generates per-operand forward selects and the load-use stall for the decode stage.
- Generalises the fixed 3-bit-register, 2-operand, EXE/MEM/WB hazard logic to any register-file size, operand count and pipeline depth.
- Adds a configurable load-result latency and a stall performance counter.

Parameters:
REG_AW, 3, register-address width.
DEPTH, 3, tracked stages after decode; index 1 = EXE, DEPTH = WB.
NUM_SRC, 2, source operands per instruction.
LOAD_READY, 2, first stage index at which load data can be forwarded (2 = MEM output).
FW, $clog2(DEPTH+1), width of one forward select.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a real instruction
id_rd  in  REG_AW  decode destination register
id_reg_wr  in  1  decode instruction writes a register
id_mem_rd  in  1  decode instruction is a load
id_src  in  NUM_SRC*REG_AW  source registers; operand i at [i*REG_AW +: REG_AW]
id_src_used  in  NUM_SRC  per-operand read enable
kill  in  1  flush decode instruction (taken branch/jump)
stat_clr  in  1  synchronous clear of stall_count
fwd_sel  out  NUM_SRC*FW  per operand: 0 = register file, k = forward from stage k
stall  out  1  hold IF/ID, bubble into EXE
stall_count  out  16  saturating count of stalled cycles

Behaviour:
- Scoreboard entries e[1..DEPTH], each holding {valid, rd, reg_wr, mem_rd}; all registered.
- Every rising edge:
  - e[k] <= e[k-1] for k = 2..DEPTH.
  - e[1] <= decode info if (id_valid & ~stall & ~kill); otherwise e[1] <= bubble (valid = 0).
  - Downstream stages never stall.
- Match for operand i at stage k: e[k].valid & e[k].reg_wr & e[k].rd == src_i & id_src_used[i].
- The youngest match (lowest k) wins. Older matches to the same register are ignored.
- hazard_i: youngest match has mem_rd = 1 and k < LOAD_READY.
- stall = id_valid & ~kill & OR(hazard_i). Combinational, same cycle as the inputs.
- fwd_sel[i] = k of the youngest match, else 0. All fwd_sel are forced to 0 while stall = 1.
- Stall duration follows from the shift: a load at e[1] with LOAD_READY = 2 gives exactly 1 stall cycle; LOAD_READY = 3 gives 2 cycles.
- kill and hazard in the same cycle: kill wins. stall = 0 and a bubble enters e[1].
- id_valid = 0: stall = 0, bubble inserted; fwd_sel is still computed but is don't-care.
- stall_count:
  - +1 on each cycle with stall = 1; saturates at 16'hFFFF without wrapping.
  - stat_clr forces 0 and has priority over increment.
- Reset, including mid-operation: all entries invalid, stall_count = 0. Hence stall = 0 and fwd_sel = 0 immediately after reset asserts; in-flight producers are discarded.
- Registers touched by the optional feature below are handled as specified there.

Optional Feature:
HAZARD_R0_ZERO_EN
- Defined: register address 0 is hardwired zero. Operands with src = 0 never match: fwd_sel = 0 and no stall. Writers with rd = 0 enter the scoreboard with reg_wr = 0.
- Undefined: register 0 is an ordinary register, handled like any other.

Test Plan:
1. Default params. ADD r3 (e[1]), then decode reads src0 = r3 -> fwd_sel[0] = 1, stall = 0. Next cycle, another reader of r3 -> fwd_sel[0] = 2.
2. LOAD r5 then reader of r5 -> stall = 1 for exactly 1 cycle, bubble in e[1]; next cycle fwd_sel = 2, stall = 0; stall_count = 1.
3. ADD r2 then LOAD r2 in flight, reader of r2 (youngest is the load at e[1]) -> stall = 1. With the ordering reversed (load older at e[2]) -> fwd_sel = 1 from the ADD, no stall.
4. Load-use hazard with kill = 1 in the same cycle -> stall = 0, e[1] bubble, stall_count unchanged.
5. LOAD_READY = 3, DEPTH = 4 -> load-use stalls 2 cycles, then fwd_sel = 3. Drive a 70000-cycle hazard -> stall_count = 16'hFFFF; stat_clr -> 0.
6. rst_n low mid-stall -> stall = 0, fwd_sel = 0 within the cycle, scoreboard empty after release. With HAZARD_R0_ZERO_EN, a write then read of r0 -> fwd_sel = 0, no stall.

Source files
------------

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight writers over DEPTH stages, drives forward selects and load-use stall.
// Latency: stall/fwd_sel combinational from decode inputs; scoreboard advances every cycle, never backpressured.
// Stall holds IF/ID and bubbles EXE; `define HAZARD_R0_ZERO_EN makes r0 hardwired zero.
module pipe_hazard_scoreboard #(
    parameter int REG_AW     = 3,
    parameter int DEPTH      = 3,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_READY = 2,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_wr,
    input  logic                      id_mem_rd,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      kill,
    input  logic                      stat_clr,
    output logic [NUM_SRC*FW-1:0]     fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_count
);

    logic [DEPTH:1]    valid_q, valid_d;
    logic [DEPTH:1]    reg_wr_q, reg_wr_d;
    logic [DEPTH:1]    mem_rd_q, mem_rd_d;
    logic [REG_AW-1:0] rd_q [1:DEPTH];
    logic [REG_AW-1:0] rd_d [1:DEPTH];
    logic [15:0]       stall_count_q, stall_count_d;

    logic [REG_AW-1:0] src_a    [NUM_SRC];
    logic [FW-1:0]     sel_raw  [NUM_SRC];
    logic [NUM_SRC-1:0] src_live;
    logic [NUM_SRC-1:0] hazard;
    logic               issue;
    logic               dst_wr;

    // Oldest-to-youngest scan so the youngest matching stage overwrites older ones.
    always_comb begin
        hazard = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_a[i]   = id_src[i*REG_AW +: REG_AW];
`ifdef HAZARD_R0_ZERO_EN
            src_live[i] = id_src_used[i] & (src_a[i] != '0);
`else
            src_live[i] = id_src_used[i];
`endif
            sel_raw[i] = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (src_live[i] && valid_q[k] && reg_wr_q[k] && (rd_q[k] == src_a[i])) begin
                    sel_raw[i] = FW'(k);
                    hazard[i]  = mem_rd_q[k] && (k < LOAD_READY);
                end
            end
        end
    end

    always_comb begin
        stall   = id_valid & ~kill & (|hazard);
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel[i*FW +: FW] = stall ? '0 : sel_raw[i];
        end
    end

    always_comb begin
        issue = id_valid & ~stall & ~kill;
`ifdef HAZARD_R0_ZERO_EN
        dst_wr = id_reg_wr & (id_rd != '0);
`else
        dst_wr = id_reg_wr;
`endif
        valid_d[1]  = issue;
        reg_wr_d[1] = issue & dst_wr;
        mem_rd_d[1] = issue & id_mem_rd;
        rd_d[1]     = id_rd;
        for (int k = 2; k <= DEPTH; k++) begin
            valid_d[k]  = valid_q[k-1];
            reg_wr_d[k] = reg_wr_q[k-1];
            mem_rd_d[k] = mem_rd_q[k-1];
            rd_d[k]     = rd_q[k-1];
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stat_clr) begin
            stall_count_d = '0;
        end else if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            reg_wr_q      <= '0;
            mem_rd_q      <= '0;
            stall_count_q <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            reg_wr_q      <= reg_wr_d;
            mem_rd_q      <= mem_rd_d;
            stall_count_q <= stall_count_d;
            for (int k = 1; k <= DEPTH; k++) begin
                rd_q[k] <= rd_d[k];
            end
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench: three configurations (default, DEPTH=4/LOAD_READY=3, DEPTH=8/LOAD_READY=8) share one stimulus stream.
module tb_pipe_hazard_scoreboard;

    localparam int FW_A = 2;
    localparam int FW_B = 3;
    localparam int FW_C = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rd;
    logic        id_reg_wr;
    logic        id_mem_rd;
    logic [5:0]  id_src;
    logic [1:0]  id_src_used;
    logic        kill;
    logic        stat_clr;

    logic [2*FW_A-1:0] fwd_a;
    logic [2*FW_B-1:0] fwd_b;
    logic [2*FW_C-1:0] fwd_c;
    logic              stall_a, stall_b, stall_c;
    logic [15:0]       cnt_a, cnt_b, cnt_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_mem_rd(id_mem_rd), .id_src(id_src), .id_src_used(id_src_used), .kill(kill),
        .stat_clr(stat_clr), .fwd_sel(fwd_a), .stall(stall_a), .stall_count(cnt_a)
    );

    pipe_hazard_scoreboard #(.DEPTH(4), .LOAD_READY(3)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_mem_rd(id_mem_rd), .id_src(id_src), .id_src_used(id_src_used), .kill(kill),
        .stat_clr(stat_clr), .fwd_sel(fwd_b), .stall(stall_b), .stall_count(cnt_b)
    );

    pipe_hazard_scoreboard #(.DEPTH(8), .LOAD_READY(8)) u_c (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_mem_rd(id_mem_rd), .id_src(id_src), .id_src_used(id_src_used), .kill(kill),
        .stat_clr(stat_clr), .fwd_sel(fwd_c), .stall(stall_c), .stall_count(cnt_c)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Set decode inputs, then let combinational outputs settle.
    task automatic apply(input logic v, input logic [2:0] rd, input logic wr, input logic mrd,
                         input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] used);
        id_valid    = v;
        id_rd       = rd;
        id_reg_wr   = wr;
        id_mem_rd   = mrd;
        id_src      = {s1, s0};
        id_src_used = used;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        apply(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
        for (int n = 0; n < 9; n++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        kill     = 1'b0;
        stat_clr = 1'b0;
        apply(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
        chk_eq("reset_stall", stall_a, 1'b0);
        chk_eq("reset_fwd", fwd_a, 4'd0);
        chk_eq("reset_count", cnt_a, 16'd0);
        #21;
        rst_n = 1'b1;
        tick();

        // ALU producer forwarded from EXE, then from MEM
        apply(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd4, 1'b1, 1'b0, 3'd3, 3'd0, 2'b01);
        chk_eq("alu_fwd_exe", fwd_a[1:0], 2'd1);
        chk_eq("alu_no_stall", stall_a, 1'b0);
        tick();
        apply(1'b1, 3'd6, 1'b0, 1'b0, 3'd3, 3'd4, 2'b11);
        chk_eq("alu_fwd_mem_op0", fwd_a[1:0], 2'd2);
        chk_eq("alu_fwd_exe_op1", fwd_a[3:2], 2'd1);
        tick();
        drain();

        // Load-use: one stall, then forward from MEM
        apply(1'b1, 3'd5, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd1, 1'b1, 1'b0, 3'd5, 3'd0, 2'b01);
        chk_eq("lu_stall", stall_a, 1'b1);
        chk_eq("lu_fwd_forced0", fwd_a, 4'd0);
        chk_eq("lu_count_before", cnt_a, 16'd0);
        tick();
        chk_eq("lu_release", stall_a, 1'b0);
        chk_eq("lu_fwd_mem", fwd_a[1:0], 2'd2);
        chk_eq("lu_count_after", cnt_a, 16'd1);
        tick();
        drain();

        // Youngest producer is the load: stall
        apply(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 3'd0, 2'b01);
        chk_eq("young_load_stall", stall_a, 1'b1);
        tick();
        chk_eq("young_load_fwd", fwd_a[1:0], 2'd2);
        chk_eq("young_load_count", cnt_a, 16'd2);
        tick();
        drain();

        // Youngest producer is the ALU op: forward, no stall
        apply(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 3'd0, 2'b01);
        chk_eq("young_alu_stall", stall_a, 1'b0);
        chk_eq("young_alu_fwd", fwd_a[1:0], 2'd1);
        tick();
        drain();

        // Kill beats hazard; killed writer must not enter the scoreboard
        apply(1'b1, 3'd5, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
        tick();
        kill = 1'b1;
        apply(1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 3'd0, 2'b01);
        chk_eq("kill_stall", stall_a, 1'b0);
        tick();
        kill = 1'b0;
        apply(1'b1, 3'd1, 1'b0, 1'b0, 3'd5, 3'd0, 2'b01);
        chk_eq("kill_bubble_fwd", fwd_a[1:0], 2'd2);
        chk_eq("kill_count", cnt_a, 16'd2);
        tick();
        drain();

        // Reset asserted during a stall
        apply(1'b1, 3'd5, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd1, 1'b1, 1'b0, 3'd5, 3'd0, 2'b01);
        chk_eq("rst_pre_stall", stall_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_eq("rst_mid_stall", stall_a, 1'b0);
        chk_eq("rst_mid_fwd", fwd_a, 4'd0);
        chk_eq("rst_mid_count", cnt_a, 16'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk_eq("rst_after_stall", stall_a, 1'b0);
        chk_eq("rst_after_fwd", fwd_a, 4'd0);
        tick();
        drain();

        // Register 0 behaviour
        apply(1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, 2'b01);
`ifdef HAZARD_R0_ZERO_EN
        chk_eq("r0_fwd", fwd_a[1:0], 2'd0);
`else
        chk_eq("r0_fwd", fwd_a[1:0], 2'd1);
`endif
        tick();
        drain();
        apply(1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, 2'b01);
`ifdef HAZARD_R0_ZERO_EN
        chk_eq("r0_load_stall", stall_a, 1'b0);
`else
        chk_eq("r0_load_stall", stall_a, 1'b1);
`endif
        tick();
        drain();

        // LOAD_READY=3, DEPTH=4: two stall cycles then forward from stage 3
        do_reset();
        apply(1'b1, 3'd5, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00);
        tick();
        apply(1'b1, 3'd1, 1'b1, 1'b0, 3'd5, 3'd0, 2'b01);
        chk_eq("lr3_stall1", stall_b, 1'b1);
        tick();
        chk_eq("lr3_stall2", stall_b, 1'b1);
        tick();
        chk_eq("lr3_release", stall_b, 1'b0);
        chk_eq("lr3_fwd", fwd_b[2:0], 3'd3);
        chk_eq("lr3_count", cnt_b, 16'd2);
        tick();
        drain();

        // Saturation: self-dependent load repeats 7 stalls in every 8 cycles on the DEPTH=8 instance
        do_reset();
        apply(1'b1, 3'd5, 1'b1, 1'b1, 3'd5, 3'd0, 2'b01);
        chk_eq("sat_first_nostall", stall_c, 1'b0);
        for (int n = 0; n < 8; n++) tick();
        chk_eq("sat_fwd_wb", fwd_c[3:0], 4'd8);
        chk_eq("sat_count_8", cnt_c, 16'd7);
        for (int n = 8; n < 75000; n++) tick();
        chk_eq("sat_count_max", cnt_c, 16'hFFFF);
        tick();
        chk_eq("sat_stalling", stall_c, 1'b1);
        tick();
        chk_eq("sat_no_wrap", cnt_c, 16'hFFFF);
        stat_clr = 1'b1;
        #1;
        chk_eq("clr_during_stall", stall_c, 1'b1);
        tick();
        chk_eq("clr_count", cnt_c, 16'd0);
        stat_clr = 1'b0;
        tick();
        chk_eq("clr_then_inc", cnt_c, 16'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
